mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the CPU's byte-wide memory bus. It serves instruction/data byte reads and byte writes issued by the core (17-bit address, 8-bit data, `mem_wr` strobe), backing them with on-chip RAM plus a small memory-mapped output port with an 8-entry FIFO toward the host. It drives the core's 2-bit halt request when the bus cannot be served: during program load, or on a write to a full output FIFO. It sits between the CPU top and the board/testbench.

## Interface
- `ADDR_W`, 17, bus address width
- `IO_BASE`, 17'h1FF00, first I/O address; RAM occupies 0..IO_BASE-1
- `FIFO_DEPTH`, 8, output FIFO entries (power of 2)

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous and active-high
- `rom_ce_i`  in  1  core bus enable; no access when 0
- `mem_a`  in  ADDR_W  byte address from core
- `mem_din`  in  8  write data from core
- `mem_wr`  in  1  1 = write, 0 = read
- `mem_dout`  out  8  read data to core (`rom_data_i` at the core)
- `halt_req_o`  out  2  to core `halt_req_i`; 2'b00 run, 2'b11 stall whole pipeline
- `ld_en`  in  1  host program-load strobe
- `ld_addr`  in  ADDR_W  load address
- `ld_data`  in  8  load byte
- `out_data`  out  8  FIFO head byte to host
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  host accepts head byte

## Operation
- Address decode: `mem_a < IO_BASE` is RAM. `IO_BASE+0` is OUT (write: push byte; read: status `{7'b0, fifo_full}`). `IO_BASE+1` is COUNT (read: `{4'b0, fifo_count}`). Other I/O addresses read 8'h00; writes to them are ignored.
- RAM write: `rom_ce_i & mem_wr & ~ld_en & ram_hit` writes `mem_din` at `mem_a`.
- RAM read: `rom_ce_i & ~mem_wr` registers `ram[mem_a]` (or I/O value) into `mem_dout`. `mem_dout` holds its value on cycles with no read.
- Load: while `ld_en`=1, `ram[ld_addr] <= ld_data` each cycle. Core writes are ignored and `halt_req_o`=2'b11. Core reads still return RAM data.
- OUT push: `rom_ce_i & mem_wr & mem_a==IO_BASE & ~fifo_full & ~ld_en` stores `mem_din` at the write pointer.
- Pop: `out_valid & out_ready` advances the read pointer. `out_data` = `fifo[rd_ptr]` (combinational from the registered array).
- FIFO: `wr_ptr`/`rd_ptr` are log2(FIFO_DEPTH) bits and wrap mod DEPTH. `fifo_count` runs 0..DEPTH. Full = count==DEPTH; empty = count==0.
- Halt: `halt_req_o` = 2'b11 combinationally when `ld_en`, or when (`rom_ce_i & mem_wr & mem_a==IO_BASE & fifo_full`). Otherwise 2'b00. The core holds address and data while stalled.
- Push while full: the push is blocked and the byte is not dropped. It completes the first cycle `fifo_full`=0.
- Push and pop in the same cycle when not full and not empty: count is unchanged and both pointers advance.
- Pop while full with a pending push: the pop happens and the push stalls this cycle, completing next cycle.

## Timing
- Read latency: exactly 1 cycle. An address presented in cycle N gives data on `mem_dout` in cycle N+1.
- A read following a write to the same RAM address in the next cycle returns the new data.
- Write latency: commits at the edge ending the cycle the write is presented. The FIFO push is visible on `out_valid` the next cycle.
- Halt is asserted in the same cycle as the blocked request, with no registered delay.
- Reset values:
  - `mem_dout`=8'h00, `out_valid`=0, `halt_req_o`=2'b00 (unless `ld_en`).
  - Pointers and count are 0.
  - RAM contents are not cleared.
- Reset mid-operation flushes the FIFO (pending bytes lost) and clears `mem_dout` the next cycle. RAM keeps its contents.

## Test plan
- Load 0x00..0x03 = 13,05,00,00 via `ld_en` (`halt_req_o`=11 throughout). Then read addr 0..3 on consecutive cycles: `mem_dout` = 13,05,00,00, each one cycle after its address.
- Write 8'hA5 to 17'h00100, read it back next cycle: 8'hA5. A write at IO_BASE+2 followed by a read there returns 00.
- With `out_ready`=0, write 'H','i' to IO_BASE: `out_valid`=1, COUNT reads 02, `out_data`='H'. Raise `out_ready`: 'H' then 'i' are popped, then `out_valid`=0.
- Fill FIFO with 8 bytes, attempt a 9th write (8'h39): `halt_req_o`=11 and COUNT=8. Pulse `out_ready` for one cycle: the 9th byte enters the following cycle, halt drops to 00, and byte order is preserved across wrap.
- Assert `rst` with 3 bytes queued: next cycle `out_valid`=0, `mem_dout`=0, COUNT=0, and previously loaded RAM bytes still read back.

Source files
------------

// File: rtl/mem_responder.sv
// Byte-wide memory responder for the core bus: on-chip RAM, a program-load port,
// and a memory-mapped output FIFO toward the host with stall (halt) signalling.
module mem_responder #(
  parameter int                 ADDR_W     = 17,
  parameter logic [ADDR_W-1:0]  IO_BASE    = 17'h1FF00,
  parameter int                 FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [ADDR_W-1:0] mem_a,
  input  logic [7:0]        mem_din,
  input  logic              mem_wr,
  output logic [7:0]        mem_dout,
  output logic [1:0]        halt_req_o,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int RAM_DEPTH = int'(IO_BASE);

  logic [7:0]       ram [0:RAM_DEPTH-1];
  logic [7:0]       fifo [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;

  logic       ram_hit;
  logic       ld_hit;
  logic       is_out;
  logic       is_cnt;
  logic       fifo_full;
  logic       out_wr;
  logic       push;
  logic       pop;
  logic       ram_wr;
  logic       rd_en;
  logic [7:0] rd_value;

  assign ram_hit   = mem_a < IO_BASE;
  assign ld_hit    = ld_addr < IO_BASE;
  assign is_out    = mem_a == IO_BASE;
  assign is_cnt    = mem_a == ADDR_W'(IO_BASE + 1'b1);
  assign fifo_full = fifo_count == CNT_W'(FIFO_DEPTH);

  // Host side follows valid/ready: a byte transfers on any rising edge where
  // out_valid and out_ready are both high; out_data is stable while out_valid
  // is high and out_ready is low.
  assign out_valid = fifo_count != '0;
  assign out_data  = fifo[rd_ptr];

  assign out_wr  = rom_ce_i & mem_wr & is_out;
  assign push    = out_wr & ~fifo_full & ~ld_en;
  assign pop     = out_valid & out_ready;
  assign ram_wr  = rom_ce_i & mem_wr & ~ld_en & ram_hit;
  assign rd_en   = rom_ce_i & ~mem_wr;

  // A blocked OUT write is held by the core until the FIFO has room.
  assign halt_req_o = (ld_en | (out_wr & fifo_full)) ? 2'b11 : 2'b00;

  always_comb begin
    rd_value = 8'h00;
    if (ram_hit)     rd_value = ram[mem_a];
    else if (is_out) rd_value = {7'b0, fifo_full};
    else if (is_cnt) rd_value = 8'(fifo_count);
  end

  // Load and core writes are mutually exclusive, so RAM keeps one write port.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      if (ld_hit) ram[ld_addr] <= ld_data;
    end else if (ram_wr) begin
      ram[mem_a] <= mem_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        mem_dout <= 8'h00;
    else if (rd_en) mem_dout <= rd_value;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: load, RAM read/write, I/O decode, FIFO
// push/pop with full-stall and wrap, and mid-operation reset.
module tb_mem_responder;

  localparam logic [16:0] IO_BASE = 17'h1FF00;
  localparam logic [16:0] IO_CNT  = 17'h1FF01;
  localparam logic [16:0] IO_OTH  = 17'h1FF02;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_i;
  logic [16:0] mem_a;
  logic [7:0]  mem_din;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [1:0]  halt_req_o;
  logic        ld_en;
  logic [16:0] ld_addr;
  logic [7:0]  ld_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] load_vals [0:3];
  logic [7:0] exp_b;

  // clock/reset block
  always #5 clk = ~clk;

  mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .rom_ce_i  (rom_ce_i),
    .mem_a     (mem_a),
    .mem_din   (mem_din),
    .mem_wr    (mem_wr),
    .mem_dout  (mem_dout),
    .halt_req_o(halt_req_o),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Advance one cycle; inputs set afterwards and outputs sampled here sit 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic core_idle();
    rom_ce_i = 1'b0;
    mem_wr   = 1'b0;
  endtask

  task automatic core_write(input logic [16:0] a, input logic [7:0] d);
    rom_ce_i = 1'b1;
    mem_wr   = 1'b1;
    mem_a    = a;
    mem_din  = d;
  endtask

  task automatic core_read(input logic [16:0] a);
    rom_ce_i = 1'b1;
    mem_wr   = 1'b0;
    mem_a    = a;
  endtask

  initial begin
    load_vals[0] = 8'h13;
    load_vals[1] = 8'h05;
    load_vals[2] = 8'h00;
    load_vals[3] = 8'h00;

    rst = 1'b1; rom_ce_i = 1'b0; mem_a = '0; mem_din = '0; mem_wr = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_dout", mem_dout, 8'h00);
    check("rst_valid", {7'b0, out_valid}, 8'h00);
    check("rst_halt", {6'b0, halt_req_o}, 8'h00);
    rst = 1'b0;
    tick();

    // program load
    for (int i = 0; i < 4; i++) begin
      ld_en = 1'b1; ld_addr = 17'(i); ld_data = load_vals[i];
      #1;
      check("load_halt", {6'b0, halt_req_o}, 8'h03);
      tick();
    end
    ld_en = 1'b0;
    #1;
    check("load_halt_off", {6'b0, halt_req_o}, 8'h00);

    for (int i = 0; i < 4; i++) begin
      core_read(17'(i));
      tick();
      check("load_readback", mem_dout, load_vals[i]);
    end

    // RAM write then read next cycle
    core_write(17'h00100, 8'hA5);
    tick();
    core_read(17'h00100);
    tick();
    check("ram_rw", mem_dout, 8'hA5);

    core_write(IO_OTH, 8'h77);
    #1;
    check("io_other_halt", {6'b0, halt_req_o}, 8'h00);
    tick();
    core_read(IO_OTH);
    tick();
    check("io_other_rd", mem_dout, 8'h00);

    core_idle();
    mem_a = 17'h00100;
    tick();
    check("dout_hold", mem_dout, 8'h00);

    // two bytes into the FIFO with the host stalled
    core_write(IO_BASE, 8'h48);
    tick();
    core_write(IO_BASE, 8'h69);
    tick();
    core_idle();
    check("hi_valid", {7'b0, out_valid}, 8'h01);
    check("hi_head", out_data, 8'h48);
    core_read(IO_CNT);
    tick();
    check("hi_count", mem_dout, 8'h02);
    core_read(IO_BASE);
    tick();
    check("hi_status", mem_dout, 8'h00);
    core_idle();
    out_ready = 1'b1;
    tick();
    check("pop_h_valid", {7'b0, out_valid}, 8'h01);
    check("pop_next", out_data, 8'h69);
    tick();
    check("pop_empty", {7'b0, out_valid}, 8'h00);
    out_ready = 1'b0;

    // fill to full starting at pointer 2, so the ring wraps
    for (int i = 0; i < 8; i++) begin
      core_write(IO_BASE, 8'(8'h30 + i));
      exp_q.push_back(8'(8'h30 + i));
      tick();
    end
    core_read(IO_CNT);
    tick();
    check("full_count", mem_dout, 8'h08);
    core_read(IO_BASE);
    tick();
    check("full_status", mem_dout, 8'h01);

    core_write(IO_BASE, 8'h39);
    #1;
    check("full_halt", {6'b0, halt_req_o}, 8'h03);
    tick();
    check("full_halt_held", {6'b0, halt_req_o}, 8'h03);
    out_ready = 1'b1;
    #1;
    check("pop_full_halt", {6'b0, halt_req_o}, 8'h03);
    tick();
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h39);
    #1;
    check("unblock_halt", {6'b0, halt_req_o}, 8'h00);
    check("unblock_head", out_data, 8'h31);
    tick();
    core_idle();

    out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      exp_b = exp_q.pop_front();
      check("drain_valid", {7'b0, out_valid}, 8'h01);
      check("drain_data", out_data, exp_b);
      tick();
    end
    check("drain_empty", {7'b0, out_valid}, 8'h00);
    out_ready = 1'b0;

    // reset with bytes queued
    for (int i = 0; i < 3; i++) begin
      core_write(IO_BASE, 8'(8'h41 + i));
      tick();
    end
    core_read(17'h00100);
    tick();
    check("pre_rst_dout", mem_dout, 8'hA5);
    check("pre_rst_valid", {7'b0, out_valid}, 8'h01);
    core_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", {7'b0, out_valid}, 8'h00);
    check("mid_rst_dout", mem_dout, 8'h00);
    core_read(IO_CNT);
    tick();
    check("mid_rst_count", mem_dout, 8'h00);
    core_read(17'h00000);
    tick();
    check("ram_kept0", mem_dout, 8'h13);
    core_read(17'h00001);
    tick();
    check("ram_kept1", mem_dout, 8'h05);
    core_read(17'h00100);
    tick();
    check("ram_kept100", mem_dout, 8'hA5);
    core_idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
